absmem_check_ctrl: RTL and testbench

ABSMEM_CHECK_CTRL -- requirements
Module: absmem_check_ctrl

---
 rtl/absmem_check_ctrl.sv | 134 +++++++++++++
 tb/tb_absmem_check_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/absmem_check_ctrl.sv
// Check-run sequencer for an abstract-memory equivalence check, plus a round-robin
// write arbiter. Optional RUN-phase timeout is enabled by defining ABSMEM_CHECK_TIMEOUT_EN.
module absmem_check_ctrl #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int MAX_CYC = 200,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          vlg_done,
   input  logic          ila_done,
   input  logic          equal,
   output logic          issue,
   output logic          compare,
   output logic          busy,
   output logic          result_valid,
   output logic          result_pass,
   output logic          result_tmo,
   input  logic          req0_wen,
   input  logic          req1_wen,
   input  logic [AW-1:0] req0_waddr,
   input  logic [AW-1:0] req1_waddr,
   input  logic [DW-1:0] req0_wdata,
   input  logic [DW-1:0] req1_wdata,
   output logic          gnt0,
   output logic          gnt1,
   output logic          m_wen,
   output logic [AW-1:0] m_waddr,
   output logic [DW-1:0] m_wdata,
   output logic [2:0]    dbg_state
);

   if (MAX_CYC < 2 || (64'(1) << CW) < 64'(MAX_CYC)) begin : g_bad_param
      $error("absmem_check_ctrl: MAX_CYC must be >= 2 and representable in CW bits");
   end

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_CMP, S_DONE} state_t;

   state_t state_q;
   logic   vd_q, id_q, ptr_q, pass_q;
   logic   done_cond, run_en;

   // Protocol: start, vlg_done and ila_done are single-cycle pulses with no back-pressure;
   // a run finishes once both done pulses have been seen since ISSUE was entered.
   assign done_cond = (vd_q | vlg_done) & (id_q | ila_done);

`ifdef ABSMEM_CHECK_TIMEOUT_EN
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);
   logic [CW-1:0] cnt_q;
   logic          tmo_q;
   assign result_tmo = tmo_q;
`else
   assign result_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vd_q    <= 1'b0;
         id_q    <= 1'b0;
         pass_q  <= 1'b0;
         ptr_q   <= 1'b1;
`ifdef ABSMEM_CHECK_TIMEOUT_EN
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         if (gnt0 | gnt1)
            ptr_q <= gnt1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ISSUE;
                  vd_q    <= 1'b0;
                  id_q    <= 1'b0;
               end
            end
            S_ISSUE: begin
               state_q <= S_RUN;
               vd_q    <= vd_q | vlg_done;
               id_q    <= id_q | ila_done;
`ifdef ABSMEM_CHECK_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_RUN: begin
               vd_q <= vd_q | vlg_done;
               id_q <= id_q | ila_done;
`ifdef ABSMEM_CHECK_TIMEOUT_EN
               cnt_q <= cnt_q + CW'(1);
`endif
               // A done arriving on the last budgeted cycle still wins over the timeout.
               if (done_cond) begin
                  state_q <= S_CMP;
               end
`ifdef ABSMEM_CHECK_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
                  tmo_q   <= 1'b1;
                  pass_q  <= 1'b0;
               end
`endif
            end
            S_CMP: begin
               state_q <= S_DONE;
               pass_q  <= equal;
`ifdef ABSMEM_CHECK_TIMEOUT_EN
               tmo_q   <= 1'b0;
`endif
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign issue        = ~rst & (state_q == S_ISSUE);
   assign compare      = ~rst & (state_q == S_CMP);
   assign result_valid = ~rst & (state_q == S_DONE);
   assign busy         = ~rst & (state_q != S_IDLE);
   assign result_pass  = pass_q;
   assign dbg_state    = state_q;

   // ptr_q names the last granted requester; on a conflict the other one wins.
   assign run_en  = ~rst & (state_q == S_RUN);
   assign gnt0    = run_en & req0_wen & (~req1_wen | ptr_q);
   assign gnt1    = run_en & req1_wen & (~req0_wen | ~ptr_q);
   assign m_wen   = gnt0 | gnt1;
   assign m_waddr = gnt0 ? req0_waddr : (gnt1 ? req1_waddr : '0);
   assign m_wdata = gnt0 ? req0_wdata : (gnt1 ? req1_wdata : '0);

endmodule

// File: tb/tb_absmem_check_ctrl.sv
// Randomized bench for absmem_check_ctrl: each run is scheduled as done-pulse offsets and
// the expected phase timing, verdict and arbitration are derived from that schedule.
module tb_absmem_check_ctrl;

   localparam int AW      = 16;
   localparam int DW      = 8;
   localparam int MAX_CYC = 200;
   localparam int CW      = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, vlg_done, ila_done, equal;
   logic          issue, compare, busy, result_valid, result_pass, result_tmo;
   logic          req0_wen, req1_wen;
   logic [AW-1:0] req0_waddr, req1_waddr;
   logic [DW-1:0] req0_wdata, req1_wdata;
   logic          gnt0, gnt1, m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [2:0]    dbg_state;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            last_gnt = 1;
   bit            track_rr = 1'b0;
   logic [AW-1:0] exp_q[$];

   absmem_check_ctrl #(.AW(AW), .DW(DW), .MAX_CYC(MAX_CYC), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .vlg_done(vlg_done), .ila_done(ila_done),
      .equal(equal), .issue(issue), .compare(compare), .busy(busy),
      .result_valid(result_valid), .result_pass(result_pass), .result_tmo(result_tmo),
      .req0_wen(req0_wen), .req1_wen(req1_wen), .req0_waddr(req0_waddr),
      .req1_waddr(req1_waddr), .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
      .gnt0(gnt0), .gnt1(gnt1), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic int imax(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver: mode 0 random requests, 1 both requesters with fixed traffic, 2 idle
   task automatic drive_reqs(input int mode);
      if (mode == 1) begin
         req0_wen = 1'b1; req0_waddr = AW'(16'h000A); req0_wdata = DW'(8'h11);
         req1_wen = 1'b1; req1_waddr = AW'(16'h000B); req1_wdata = DW'(8'h22);
      end else begin
         req0_wen   = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         req1_wen   = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         req0_waddr = AW'($urandom);
         req1_waddr = AW'($urandom);
         req0_wdata = DW'($urandom);
         req1_wdata = DW'($urandom);
      end
   endtask

   // reference arbiter: sole requester wins, a conflict goes to whoever was not granted last
   task automatic check_arb(input bit in_run);
      int            win;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      win = -1;
      if (in_run) begin
         if (req0_wen && req1_wen) win = 1 - last_gnt;
         else if (req0_wen)        win = 0;
         else if (req1_wen)        win = 1;
      end
      ea = (win == 0) ? req0_waddr : ((win == 1) ? req1_waddr : '0);
      ed = (win == 0) ? req0_wdata : ((win == 1) ? req1_wdata : '0);
      check("gnt0", gnt0, win == 0);
      check("gnt1", gnt1, win == 1);
      check("m_wen", m_wen, win >= 0);
      check("m_waddr", m_waddr, ea);
      check("m_wdata", m_wdata, ed);
      if (win >= 0) last_gnt = win;
      if (track_rr && m_wen) begin
         logic [AW-1:0] e;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         check("rr_seq", m_waddr, e);
      end
   endtask

   // One run: vlg_done pulses a cycles after ISSUE, ila_done b cycles after ISSUE.
   task automatic run_one(input int a, input int b, input bit eq, input int req_mode);
      int d, c_cmp, c_done, run_end;
      bit tmo, in_run, spare;
      d       = imax(imax(a, b), 1);
      tmo     = 1'b0;
      c_cmp   = d + 2;
      c_done  = d + 3;
      run_end = d + 1;
`ifdef ABSMEM_CHECK_TIMEOUT_EN
      if (d > MAX_CYC) begin
         tmo = 1'b1; c_cmp = -1; run_end = MAX_CYC + 1; c_done = MAX_CYC + 2;
      end
`endif
      for (int c = 0; c <= c_done + 1; c++) begin
         in_run   = (c >= 2) && (c <= run_end);
         spare    = (c == 0) || (c > run_end);
         start    = (c == 0) || (c <= c_done && $urandom_range(0, 3) == 0);
         vlg_done = (c == 1 + a) || (spare && $urandom_range(0, 1) == 1);
         ila_done = (c == 1 + b) || (spare && $urandom_range(0, 1) == 1);
         equal    = (c == c_cmp) ? eq : 1'($urandom_range(0, 1));
         if (req_mode == 1) drive_reqs((in_run && c <= 5) ? 1 : 2);
         else drive_reqs(req_mode);
         @(negedge clk);
         check("issue", issue, c == 1);
         check("busy", busy, c >= 1 && c <= c_done);
         check("compare", compare, c == c_cmp);
         check("result_valid", result_valid, c == c_done);
         if (c >= c_done) begin
            check("result_pass", result_pass, tmo ? 1'b0 : eq);
            check("result_tmo", result_tmo, tmo);
         end
         check_arb(in_run);
         @(posedge clk); #1;
      end
      start = 1'b0; vlg_done = 1'b0; ila_done = 1'b0;
   endtask

   // Run with no ila_done for n cycles, then reset in the middle of RUN.
   task automatic hang_reset(input int n);
      for (int c = 0; c <= n + 1; c++) begin
         start    = (c == 0);
         vlg_done = (c == 3);
         ila_done = 1'b0;
         equal    = 1'($urandom_range(0, 1));
         drive_reqs(0);
         @(negedge clk);
         check("hang_busy", busy, c >= 1);
         check("hang_compare", compare, 1'b0);
         check("hang_valid", result_valid, 1'b0);
         check_arb(c >= 2);
         @(posedge clk); #1;
      end
      rst = 1'b1; start = 1'b0; vlg_done = 1'b0;
      req0_wen = 1'b1; req1_wen = 1'b0; req0_waddr = AW'(16'h0055);
      @(negedge clk);
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_m_wen", m_wen, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_gnt = 1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_issue", issue, 1'b0);
      check("post_rst_gnt0", gnt0, 1'b0);
      check("post_rst_m_wen", m_wen, 1'b0);
      check("post_rst_pass", result_pass, 1'b0);
      check("post_rst_tmo", result_tmo, 1'b0);
      @(posedge clk); #1;
      req0_wen = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vlg_done = 1'b0; ila_done = 1'b0; equal = 1'b0;
      drive_reqs(2);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_issue", issue, 1'b0);
      check("reset_compare", compare, 1'b0);
      check("reset_valid", result_valid, 1'b0);
      check("reset_pass", result_pass, 1'b0);
      check("reset_tmo", result_tmo, 1'b0);
      check("reset_m_wen", m_wen, 1'b0);
      @(posedge clk); #1;

      // Fixed conflicting traffic right after reset: req0 wins first, then alternation.
      exp_q = {AW'(16'h000A), AW'(16'h000B), AW'(16'h000A), AW'(16'h000B)};
      track_rr = 1'b1;
      run_one(5, 5, 1'b0, 1);
      track_rr = 1'b0;
      check("rr_seq_len", exp_q.size(), 0);

      run_one(3, 6, 1'b1, 0);   // vlg_done at RUN+2, ila_done at RUN+5
      run_one(4, 4, 1'b0, 0);   // simultaneous dones, mismatch
      run_one(0, 0, 1'b1, 0);   // both dones during ISSUE
      run_one(7, 1, 1'b1, 0);
      for (int i = 0; i < 30; i++)
         run_one($urandom_range(0, 8), $urandom_range(0, 8), 1'($urandom_range(0, 1)), 0);

`ifdef ABSMEM_CHECK_TIMEOUT_EN
      run_one(0, 1000, 1'b1, 0);          // ila_done never comes: timeout verdict
      run_one(MAX_CYC, 2, 1'b1, 0);       // done on the last budgeted cycle beats timeout
`endif
      run_one(1, 2, 1'b1, 0);             // leave result_pass=1 before the reset test
      hang_reset(50);
      run_one($urandom_range(0, 5), $urandom_range(0, 5), 1'b1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
